// File: rtl/fsm2_pkg.sv
// Shared definitions for FSM2 (states A..F, input x, Mealy output) and its stimulus driver.
// Imported by FSM2 itself, by the shadow model and by the driver.
package fsm2_pkg;

    typedef enum logic [2:0] {
        A = 3'd0,
        B = 3'd1,
        C = 3'd2,
        D = 3'd3,
        E = 3'd4,
        F = 3'd5
    } fsm2_state_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GOTO = 3'd1,
        SEND = 3'd2,
        RSTA = 3'd3,
        DONE = 3'd4
    } ctrl_state_t;

    localparam logic CMD_GOTO = 1'b0;
    localparam logic CMD_SEND = 1'b1;

    function automatic fsm2_state_t next_fn(input fsm2_state_t s, input logic x);
        case (s)
            A:       return x ? D : E;
            B:       return x ? D : F;
            C:       return x ? B : E;
            D:       return x ? B : F;
            E:       return x ? F : C;
            F:       return x ? C : B;
            default: return A;
        endcase
    endfunction

    function automatic logic out_fn(input fsm2_state_t s, input logic x);
        return x && (s == A || s == C || s == E);
    endfunction

    // First x bit of a BFS shortest path from s to t (ties resolved to x=0).
    // Row per target, bit index = current state; A is unreachable and handled by a reset.
    function automatic logic next_hop(input fsm2_state_t s, input fsm2_state_t t);
        logic [5:0] row;
        case (t)
            B:       row = 6'b001101;
            C:       row = 6'b100000;
            D:       row = 6'b000111;
            E:       row = 6'b100000;
            F:       row = 6'b010000;
            default: row = 6'b000000;
        endcase
        return (s <= F) ? row[s] : 1'b0;
    endfunction

endpackage

// File: rtl/fsm2_shadow.sv
// Cycle-exact shadow of FSM2: same next-state register, fsm_rst override and
// a combinational prediction of FSM2's Mealy output.
module fsm2_shadow
    import fsm2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       fsm_rst,
    input  logic       x,
    output logic [2:0] state,
    output logic       exp_outp
);

    fsm2_state_t st_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q <= A;
        end else if (fsm_rst) begin
            st_q <= A;
        end else begin
            st_q <= next_fn(st_q, x);
        end
    end

    assign state    = st_q;
    assign exp_outp = out_fn(st_q, x);

endmodule

// File: rtl/fsm2_stim_driver.sv
// Drives FSM2's serial input x from GOTO/SEND commands while keeping a shadow
// copy of FSM2's state and its predicted output.
module fsm2_stim_driver
    import fsm2_pkg::*;
#(
    parameter logic        IDLE_X  = 1'b0,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_cmd,
    input  logic [2:0] req_target,
    input  logic [7:0] req_pattern,
    input  logic [3:0] req_len,
    output logic       x_out,
    output logic       fsm_rst,
    output logic       exp_outp,
    output logic [2:0] shadow_st,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);

    ctrl_state_t ctrl_q, ctrl_d;
    fsm2_state_t shadow, start_st;
    logic [2:0]  target_q;
    logic [7:0]  pat_q;
    logic [3:0]  len_q;
    logic [2:0]  idx_q;
    logic        err_q;
    logic        fsm_rst_q;
    logic        accept;
    logic        bad_cmd;

    fsm2_shadow u_shadow (
        .clk      (clk),
        .reset    (reset),
        .fsm_rst  (fsm_rst_q),
        .x        (x_out),
        .state    (shadow_st),
        .exp_outp (exp_outp)
    );

    assign shadow = fsm2_state_t'(shadow_st);

    // FSM2 still steps on IDLE_X at the accept edge, so the walk starts from that state.
    assign start_st = next_fn(shadow, IDLE_X);
    assign accept   = (ctrl_q == IDLE) && req_valid;
    assign bad_cmd  = (req_cmd == CMD_SEND) ? (req_len > MAX_LEN_W) : (req_target > 3'd5);

    always_comb begin
        x_out = IDLE_X;
        case (ctrl_q)
            GOTO:    x_out = next_hop(shadow, fsm2_state_t'(target_q));
            SEND:    x_out = pat_q[idx_q];
            default: x_out = IDLE_X;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad_cmd) begin
                        ctrl_d = DONE;
                    end else if (req_cmd == CMD_GOTO) begin
                        if (req_target == start_st) begin
                            ctrl_d = DONE;
                        end else if (req_target == A) begin
                            ctrl_d = RSTA;
                        end else begin
                            ctrl_d = GOTO;
                        end
                    end else begin
                        ctrl_d = (req_len == 4'd0) ? DONE : SEND;
                    end
                end
            end
            GOTO: begin
                if (next_fn(shadow, x_out) == fsm2_state_t'(target_q)) begin
                    ctrl_d = DONE;
                end
            end
            SEND: begin
                if ({1'b0, idx_q} == len_q - 4'd1) begin
                    ctrl_d = DONE;
                end
            end
            RSTA:    ctrl_d = DONE;
            DONE:    ctrl_d = IDLE;
            default: ctrl_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= IDLE;
            target_q  <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            fsm_rst_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            fsm_rst_q <= (ctrl_d == RSTA);
            if (accept) begin
                target_q <= req_target;
                pat_q    <= req_pattern;
                len_q    <= req_len;
                idx_q    <= '0;
                err_q    <= bad_cmd;
            end else if (ctrl_q == SEND) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    assign req_ready = (ctrl_q == IDLE);
    assign fsm_rst   = fsm_rst_q;
    assign done      = (ctrl_q == DONE);
    assign err       = (ctrl_q == DONE) && err_q;

endmodule
